// File: rtl/operand_pipe_reg_pkg.sv
// Shared constants and helpers for the operand pipeline register slice.
package operand_pipe_reg_pkg;

  localparam int OPERAND_WIDTH       = 32;
  localparam int PIPE_STAGES_DEFAULT = 1;

  // Width of a counter that must hold 0..2*stages (one main plus one skid word per stage).
  function automatic int cntWidth(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// One pipeline stage: a main register feeding downstream plus a skid register
// that absorbs the word arriving in the cycle downstream stalls.
module pipe_skid_stage
  import operand_pipe_reg_pkg::*;
#(
  parameter int WIDTH = OPERAND_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData
);

  logic             mainValid;
  logic             skidValid;
  logic [WIDTH-1:0] mainData;
  logic [WIDTH-1:0] skidData;
  logic             inFire;
  logic             mainLoad;

  // Ready is a pure flop: the stage accepts whenever the skid slot is free.
  assign inReady  = ~skidValid;
  assign outValid = mainValid;
  assign outData  = mainData;
  assign inFire   = inValid & inReady;
  assign mainLoad = ~mainValid | outReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      mainData  <= '0;
      skidData  <= '0;
    end else if (flush) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
    end else if (mainLoad) begin
      // A full skid always drains first; inFire is then 0 because ready was low.
      mainValid <= skidValid | inFire;
      skidValid <= 1'b0;
      if (skidValid) begin
        mainData <= skidData;
      end else if (inFire) begin
        mainData <= inData;
      end
    end else if (inFire) begin
      skidValid <= 1'b1;
      skidData  <= inData;
    end
  end

endmodule

// File: rtl/operand_pipe_reg.sv
// Operand pipeline register: STAGES chained skid stages with fully registered
// ready, flush squash and an occupancy count of held words.
module operand_pipe_reg
  import operand_pipe_reg_pkg::*;
#(
  parameter int  WIDTH  = OPERAND_WIDTH,
  parameter int  STAGES = PIPE_STAGES_DEFAULT,
  localparam int CNT_W  = cntWidth(STAGES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  // Handshake: a word moves on a rising edge only when valid and ready are both
  // high on that interface; valid never waits on ready and held words stay stable.
  logic [STAGES:0] validChain;
  logic [STAGES:0] readyChain;
  logic [WIDTH-1:0] dataChain [STAGES+1];
  logic            inXfer;
  logic            outXfer;

  assign validChain[0]      = in_valid;
  assign dataChain[0]       = in_data;
  assign readyChain[STAGES] = out_ready;
  assign out_valid          = validChain[STAGES];
  assign out_data           = dataChain[STAGES];
  assign in_ready           = readyChain[0] & ~flush;

  for (genvar g = 0; g < STAGES; g++) begin : gStage
    pipe_skid_stage #(.WIDTH(WIDTH)) uStage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .inValid  (validChain[g]),
      .inReady  (readyChain[g]),
      .inData   (dataChain[g]),
      .outValid (validChain[g+1]),
      .outReady (readyChain[g+1]),
      .outData  (dataChain[g+1])
    );
  end

  assign inXfer  = in_valid & in_ready;
  assign outXfer = out_valid & out_ready;

  // Internal stage-to-stage moves never change the number of held words.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occupancy <= '0;
    end else begin
      case ({inXfer, outXfer})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_pipe_reg.sv
// Directed bench for operand_pipe_reg with STAGES = 1, 2 and 3 instances.
module tb_operand_pipe_reg;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  logic        iv1, ir1, ov1, or1, fl1;
  logic [31:0] id1, od1;
  logic [1:0]  occ1;
  logic        iv2, ir2, ov2, or2, fl2;
  logic [31:0] id2, od2;
  logic [2:0]  occ2;
  logic        iv3, ir3, ov3, or3, fl3;
  logic [31:0] id3, od3;
  logic [2:0]  occ3;

  operand_pipe_reg #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_data(id1), .flush(fl1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1));
  operand_pipe_reg #(.WIDTH(32), .STAGES(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .in_data(id2), .flush(fl2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .occupancy(occ2));
  operand_pipe_reg #(.WIDTH(32), .STAGES(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(ir3), .in_data(id3), .flush(fl3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .occupancy(occ3));

  typedef struct packed {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        eov;
    logic [31:0] eod;
    logic        eir;
    logic [1:0]  eocc;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleAll();
    iv1 = 0; id1 = '0; or1 = 0; fl1 = 0;
    iv2 = 0; id2 = '0; or2 = 0; fl2 = 0;
    iv3 = 0; id3 = '0; or3 = 0; fl3 = 0;
  endtask

  task automatic doReset();
    idleAll();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] words [5];
    logic [31:0] expWord;
    bit eAccepted;
    int emitted;

    reset = 1'b1;
    idleAll();

    // STAGES=1 cycle table: inputs this cycle, outputs seen before the edge.
    //            iv    d          or    fl    eov   eod        eir   eocc
    vecs[0]  = '{1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 32'h0,     1'b1, 2'd0};
    vecs[1]  = '{1'b1, 32'h5,     1'b1, 1'b0, 1'b0, 32'h0,     1'b1, 2'd0};
    vecs[2]  = '{1'b0, 32'h0,     1'b1, 1'b0, 1'b1, 32'h5,     1'b1, 2'd1};
    vecs[3]  = '{1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 32'h5,     1'b1, 2'd0};
    vecs[4]  = '{1'b1, 32'h11,    1'b0, 1'b0, 1'b0, 32'h5,     1'b1, 2'd0};
    vecs[5]  = '{1'b1, 32'h22,    1'b0, 1'b0, 1'b1, 32'h11,    1'b1, 2'd1};
    vecs[6]  = '{1'b1, 32'h33,    1'b0, 1'b0, 1'b1, 32'h11,    1'b0, 2'd2};
    vecs[7]  = '{1'b1, 32'h33,    1'b1, 1'b0, 1'b1, 32'h11,    1'b0, 2'd2};
    vecs[8]  = '{1'b1, 32'h33,    1'b1, 1'b0, 1'b1, 32'h22,    1'b1, 2'd1};
    vecs[9]  = '{1'b0, 32'h0,     1'b1, 1'b0, 1'b1, 32'h33,    1'b1, 2'd1};
    vecs[10] = '{1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h33,    1'b1, 2'd0};
    vecs[11] = '{1'b1, 32'h44,    1'b0, 1'b0, 1'b0, 32'h33,    1'b1, 2'd0};
    vecs[12] = '{1'b1, 32'h55,    1'b0, 1'b1, 1'b1, 32'h44,    1'b0, 2'd1};
    vecs[13] = '{1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 32'h44,    1'b1, 2'd0};

    doReset();
    for (int i = 0; i < 14; i++) begin
      iv1 = vecs[i].iv; id1 = vecs[i].d; or1 = vecs[i].ordy; fl1 = vecs[i].fl;
      #2;
      check($sformatf("s1_v%0d_out_valid", i), 64'(ov1), 64'(vecs[i].eov));
      check($sformatf("s1_v%0d_out_data", i), 64'(od1), 64'(vecs[i].eod));
      check($sformatf("s1_v%0d_in_ready", i), 64'(ir1), 64'(vecs[i].eir));
      check($sformatf("s1_v%0d_occupancy", i), 64'(occ1), 64'(vecs[i].eocc));
      step();
    end

    // STAGES=3 streaming: 1..10 back to back, each out 3 cycles later, no gaps.
    doReset();
    for (int c = 0; c < 16; c++) begin
      iv3 = (c < 10); id3 = 32'(c + 1); or3 = 1'b1;
      #2;
      if (c < 10) check($sformatf("s3_c%0d_in_ready", c), 64'(ir3), 64'd1);
      check($sformatf("s3_c%0d_out_valid", c), 64'(ov3), 64'((c >= 3) && (c < 13)));
      if ((c >= 3) && (c < 13)) check($sformatf("s3_c%0d_out_data", c), 64'(od3), 64'(c - 2));
      step();
    end
    check("s3_final_occupancy", 64'(occ3), 64'd0);

    // STAGES=2 backpressure: four words fill both stages, fifth is refused.
    doReset();
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC; words[3] = 32'hD; words[4] = 32'hE;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      iv2 = 1'b1; id2 = words[i];
      #2;
      check($sformatf("bp_accept%0d_in_ready", i), 64'(ir2), 64'd1);
      exp_q.push_back(words[i]);
      step();
    end
    iv2 = 1'b1; id2 = words[4];
    #2;
    check("bp_full_in_ready", 64'(ir2), 64'd0);
    check("bp_full_occupancy", 64'(occ2), 64'd4);
    check("bp_full_out_data", 64'(od2), 64'hA);
    step();
    or2 = 1'b1;
    eAccepted = 0;
    emitted = 0;
    for (int c = 0; c < 20 && (!eAccepted || exp_q.size() != 0); c++) begin
      #2;
      if (c == 0) check("bp_release_in_ready_still_low", 64'(ir2), 64'd0);
      if (ov2) begin
        emitted++;
        if (exp_q.size() == 0) begin
          check("bp_extra_word", 64'(od2), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          expWord = exp_q.pop_front();
          check($sformatf("bp_order%0d", emitted), 64'(od2), 64'(expWord));
        end
      end
      if (iv2 && ir2) begin
        exp_q.push_back(words[4]);
        eAccepted = 1;
      end
      step();
      if (eAccepted) iv2 = 1'b0;
    end
    check("bp_fifth_accepted", 64'(eAccepted), 64'd1);
    check("bp_all_emitted", 64'(emitted), 64'd5);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // STAGES=2 flush with three words held and a same-cycle push of 0x77.
    doReset();
    for (int i = 0; i < 3; i++) begin
      iv2 = 1'b1; id2 = 32'(i + 1);
      #2;
      check($sformatf("fl_push%0d_in_ready", i), 64'(ir2), 64'd1);
      step();
    end
    iv2 = 1'b1; id2 = 32'h77; fl2 = 1'b1;
    #2;
    check("fl_pre_occupancy", 64'(occ2), 64'd3);
    check("fl_in_ready_low", 64'(ir2), 64'd0);
    step();
    iv2 = 1'b0; fl2 = 1'b0;
    #2;
    check("fl_post_occupancy", 64'(occ2), 64'd0);
    check("fl_post_out_valid", 64'(ov2), 64'd0);
    check("fl_data_kept", 64'(od2), 64'd1);
    or2 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      #2;
      check($sformatf("fl_never_out%0d", c), 64'(ov2), 64'd0);
    end
    step();

    // STAGES=2 stall: 0xDEADBEEF must hold for 5 stalled cycles.
    doReset();
    iv2 = 1'b1; id2 = 32'hDEAD_BEEF;
    #2;
    check("st_in_ready", 64'(ir2), 64'd1);
    step();
    iv2 = 1'b0;
    for (int c = 0; c < 10 && !ov2; c++) step();
    check("st_reach_output", 64'(ov2), 64'd1);
    for (int c = 0; c < 5; c++) begin
      #2;
      check($sformatf("st_hold%0d_data", c), 64'(od2), 64'hDEAD_BEEF);
      check($sformatf("st_hold%0d_valid", c), 64'(ov2), 64'd1);
      step();
    end

    // STAGES=2 mid-stream reset with two words held.
    doReset();
    iv2 = 1'b1; id2 = 32'h12;
    step();
    id2 = 32'h34;
    step();
    iv2 = 1'b0;
    #2;
    check("mr_pre_occupancy", 64'(occ2), 64'd2);
    check("mr_pre_out_data", 64'(od2), 64'h12);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #2;
    check("mr_out_data", 64'(od2), 64'd0);
    check("mr_out_valid", 64'(ov2), 64'd0);
    check("mr_in_ready", 64'(ir2), 64'd1);
    check("mr_occupancy", 64'(occ2), 64'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
